// File: rtl/button_conditioner.sv
// Push-button conditioner: a 2-flop synchronizer and a debounce FSM per
// channel. Each FSM emits a debounced level and one-cycle press and release
// pulses. step_pulse drives the duty-cycle step inputs of the PWM counter.
// Optional feature: define BUTTON_AUTOREPEAT_EN to add auto-repeat on
// step_pulse while a button stays held. Without it, step_pulse == press_pulse.
module button_conditioner #(
  parameter int NUM_BTN       = 2,
  parameter int DB_TICKS      = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 5
) (
  input  logic               clk,
  input  logic               restart,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] step_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal counts. A counter reloads on reaching its terminal value and
  // never goes past it.
  localparam logic [7:0] DB_LAST = 8'(DB_TICKS - 1);

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  // Two-flop synchronizer for the asynchronous button levels
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    state_t     r_state;
    logic [7:0] r_db_cnt;
    logic       r_held;
    logic       r_press;
    logic       r_release;
    logic       w_sync;
    logic       w_press_evt;
    logic       w_release_evt;

    assign w_sync        = r_sync2[g];
    assign w_press_evt   = (r_state == PRESS_WAIT)   &&  w_sync && (r_db_cnt == DB_LAST);
    assign w_release_evt = (r_state == RELEASE_WAIT) && !w_sync && (r_db_cnt == DB_LAST);

    // Debounce FSM. The outputs are registered and change together with the state.
    always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
        r_state   <= IDLE;
        r_db_cnt  <= '0;
        r_held    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        // NOTE: pulses default low every cycle, so each event lasts exactly one cycle.
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_sync) begin
              r_state  <= PRESS_WAIT;
              r_db_cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!w_sync) begin
              r_state <= IDLE;
            end else if (w_press_evt) begin
              r_state <= HELD;
              r_held  <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + 8'd1;
            end
          end
          HELD: begin
            if (!w_sync) begin
              r_state  <= RELEASE_WAIT;
              r_db_cnt <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (w_sync) begin
              r_state <= HELD;
            end else if (w_release_evt) begin
              r_state   <= IDLE;
              r_held    <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + 8'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end

    assign held[g]          = r_held;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [7:0] REP_DELAY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] REP_PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

    logic [7:0] r_rep_cnt;
    logic       r_rep_phase;  // 0: waiting for the first repeat, 1: periodic repeats
    logic       r_step;
    logic [7:0] w_rep_last;

    assign w_rep_last = r_rep_phase ? REP_PERIOD_LAST : REP_DELAY_LAST;

    // Repeat timer: counts only while in HELD with the button down. Any other
    // state clears it, so a bounce back into HELD restarts the first-repeat delay.
    always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
        r_step      <= 1'b0;
      end else begin
        r_step <= 1'b0;
        if (w_press_evt) begin
          r_step      <= 1'b1;
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b0;
        end else if (r_state == HELD && w_sync) begin
          if (r_rep_cnt == w_rep_last) begin
            r_step      <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 8'd1;
          end
        end else begin
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b0;
        end
      end
    end

    assign step_pulse[g] = r_step;
`else
    assign step_pulse[g] = r_press;
`endif
  end

endmodule
